// File: rtl/axi_sub_comp_arb_pkg.sv
// Shared helpers for the component-interface arbiter: size field width and
// modulo-N index arithmetic used by the round-robin search and pointer update.
package axi_sub_comp_arb_pkg;

  localparam int SIZE_W = 3;

  function automatic int wrap_add(input int base, input int k, input int n);
    int s;
    s = base + k;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/axi_sub_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, with wrap.
// Returns both the one-hot grant and its encoded index.
module axi_sub_rr_pick
  import axi_sub_comp_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int NW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [NW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_add(int'(ptr), k, N)]) begin
        found = 1'b1;
        idx   = NW'(wrap_add(int'(ptr), k, N));
        gnt[wrap_add(int'(ptr), k, N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_sub_comp_arb.sv
// N-way round-robin arbiter sharing one component command interface; grants whole
// bursts, routes write errors to the winner and steers read returns by origin port.
module axi_sub_comp_arb
  import axi_sub_comp_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  parameter  int UW    = 32,
  parameter  int IW    = 1,
  parameter  int C_LAT = 0,
  localparam int NW    = $clog2(N),
  localparam int BC    = DW / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_dv,
  input  logic [N*AW-1:0]     req_addr,
  input  logic [N-1:0]        req_write,
  input  logic [N*UW-1:0]     req_user,
  input  logic [N*IW-1:0]     req_id,
  input  logic [N*DW-1:0]     req_wdata,
  input  logic [N*BC-1:0]     req_wstrb,
  input  logic [N*SIZE_W-1:0] req_size,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_hld,
  output logic [N-1:0]        req_wr_err,
  output logic [N-1:0]        req_rd_vld,
  output logic [N-1:0]        req_rd_err,
  output logic [DW-1:0]       req_rdata,
  output logic                dv,
  output logic [AW-1:0]       addr,
  output logic                write,
  output logic [UW-1:0]       user,
  output logic [IW-1:0]       id,
  output logic [DW-1:0]       wdata,
  output logic [BC-1:0]       wstrb,
  output logic [SIZE_W-1:0]   size,
  output logic                last,
  input  logic                hld,
  input  logic                rd_err,
  input  logic                wr_err,
  input  logic [DW-1:0]       rdata
);

  logic          lock_q;
  logic [NW-1:0] lock_idx_q;
  logic [NW-1:0] ptr_q;
  logic [N-1:0]  pick_gnt;
  logic [NW-1:0] pick_idx;
  logic [N-1:0]  gnt;
  logic [NW-1:0] win;
  logic          acc;
  logic          acc_last;

  axi_sub_rr_pick #(.N(N)) u_pick (
    .req (req_dv),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant is forced to zero while reset is asserted so outputs idle immediately.
  always_comb begin
    gnt = '0;
    win = '0;
    if (rst_n) begin
      if (lock_q) begin
        gnt[lock_idx_q] = 1'b1;
        win             = lock_idx_q;
      end else begin
        gnt = pick_gnt;
        win = pick_idx;
      end
    end
  end

  always_comb begin
    dv    = |(req_dv & gnt);
    addr  = '0;
    write = 1'b0;
    user  = '0;
    id    = '0;
    wdata = '0;
    wstrb = '0;
    size  = '0;
    last  = 1'b0;
    if (|gnt) begin
      addr  = req_addr[win*AW +: AW];
      write = req_write[win];
      user  = req_user[win*UW +: UW];
      id    = req_id[win*IW +: IW];
      wdata = req_wdata[win*DW +: DW];
      wstrb = req_wstrb[win*BC +: BC];
      size  = req_size[win*SIZE_W +: SIZE_W];
      last  = req_last[win];
    end
  end

  assign acc      = dv && !hld;
  assign acc_last = acc && last;

  // Any live beat that is not an accepted last keeps the winner locked; a dropped
  // req_dv on the locked port falls out of the same expression and unlocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
    end else begin
      lock_q <= dv && !acc_last;
      if (dv && !acc_last) lock_idx_q <= win;
      if (acc_last) ptr_q <= NW'(wrap_add(int'(win), 1, N));
    end
  end

  assign req_hld    = {N{hld}} | ~gnt;
  assign req_wr_err = gnt & {N{wr_err && dv && write}};
  assign req_rd_err = req_rd_vld & {N{rd_err}};
  assign req_rdata  = rdata;

  if (C_LAT == 0) begin : g_rd_comb
    assign req_rd_vld = gnt & {N{acc && !write}};
  end else begin : g_rd_pipe
    typedef struct packed {
      logic          vld;
      logic [NW-1:0] idx;
    } rd_ent_t;

    rd_ent_t          rd_push_p0;
    logic [C_LAT-1:0] rd_vld_p;
    logic [NW-1:0]    rd_idx_p [C_LAT];

    assign rd_push_p0 = '{vld: acc && !write, idx: win};

    // Return pipeline: stage s holds reads accepted s+1 cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_vld_p <= '0;
      end else begin
        rd_vld_p[0] <= rd_push_p0.vld;
        for (int s = 1; s < C_LAT; s++) rd_vld_p[s] <= rd_vld_p[s-1];
      end
    end

    always_ff @(posedge clk) begin
      rd_idx_p[0] <= rd_push_p0.idx;
      for (int s = 1; s < C_LAT; s++) rd_idx_p[s] <= rd_idx_p[s-1];
    end

    always_comb begin
      req_rd_vld = '0;
      req_rd_vld[rd_idx_p[C_LAT-1]] = rd_vld_p[C_LAT-1];
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_lock_keeps_dv: assert property (@(posedge clk) disable iff (!rst_n)
    lock_q |-> req_dv[lock_idx_q]);
  a_no_acc_on_hld: assert property (@(posedge clk) disable iff (!rst_n)
    hld |-> !(|(req_dv & ~req_hld)));

endmodule
